// File: rtl/aes_core_arbiter.sv
// Round-robin front end that shares one multicycle AES-128 core among N_REQ requesters.
// Define AES_ARB_STATS_EN to add the saturating completion counter output stat_blocks.
module aes_core_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*128-1:0] req_data,
  input  logic [N_REQ*128-1:0] req_key,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [127:0]         resp_data,
  output logic [127:0]         core_in,
  output logic [127:0]         core_key,
  input  logic                 core_ready,
  input  logic                 core_valid,
  input  logic [127:0]         core_out
`ifdef AES_ARB_STATS_EN
  ,
  output logic [15:0]          stat_blocks
`endif
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam logic [TAG_W:0]   NREQ_W = (TAG_W+1)'(N_REQ);
  localparam logic [TAG_W-1:0] LAST   = TAG_W'(N_REQ-1);

  logic             stg_full;
  logic [127:0]     stg_data;
  logic [127:0]     stg_key;
  logic [TAG_W-1:0] stg_tag;
  logic             fl_busy;
  logic [TAG_W-1:0] fl_tag;
  logic [TAG_W-1:0] rr_ptr;

  logic             grant_hit;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W:0]   cand;

  function automatic logic [N_REQ-1:0] onehot(input logic [TAG_W-1:0] t);
    return {{(N_REQ-1){1'b0}}, 1'b1} << t;
  endfunction

  assign core_in  = stg_data;
  assign core_key = stg_key;

  // Grant: first valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!rst && !stg_full) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (TAG_W+1)'(k);
        if (cand >= NREQ_W) cand = cand - NREQ_W;
        if (!grant_hit && req_valid[cand[TAG_W-1:0]]) begin
          grant_hit = 1'b1;
          grant_idx = cand[TAG_W-1:0];
        end
      end
    end
    req_ready = grant_hit ? onehot(grant_idx) : '0;
  end

  // Staging, in-flight tag and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_full   <= 1'b0;
      stg_data   <= '0;
      stg_key    <= '0;
      stg_tag    <= '0;
      fl_busy    <= 1'b0;
      fl_tag     <= '0;
      rr_ptr     <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= '0;
      if (core_valid && fl_busy) begin
        resp_valid <= onehot(fl_tag);
        resp_data  <= core_out;
        fl_busy    <= 1'b0;
      end
      // An issue in the same cycle overrides the completion's clear of fl_busy.
      if (core_ready && stg_full) begin
        fl_busy  <= 1'b1;
        fl_tag   <= stg_tag;
        stg_full <= 1'b0;
      end
      if (grant_hit) begin
        stg_full <= 1'b1;
        stg_data <= req_data[{grant_idx, 7'd0} +: 128];
        stg_key  <= req_key[{grant_idx, 7'd0} +: 128];
        stg_tag  <= grant_idx;
        rr_ptr   <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef AES_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_blocks <= '0;
    end else if (core_valid && fl_busy && stat_blocks != 16'hFFFF) begin
      stat_blocks <= stat_blocks + 16'd1;
    end
  end
`endif

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Round-robin arbiter that shares one fine-multicycle AES-128 core among `N_REQ` requesters. It accepts one plaintext/key pair at a time into a staging register and presents it to the core until the core's `ready` pulse samples it. It tags the in-flight block with its requester index and routes the core's `valid` result back to that requester as a registered one-cycle response. The block sits between the requester ports and the core's `in_bus`/`key`/`ready`/`valid`/`out_bus`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16. The tag width is `TAG_W = $clog2(N_REQ)`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: requester i offers a block.
- `req_ready` output N_REQ: one-hot or zero; requester i is granted this cycle.
- `req_data` input N_REQ*128: plaintext, requester i at `[128*i +: 128]`.
- `req_key` input N_REQ*128: key, same packing.
- `resp_valid` output N_REQ: one-cycle pulse; `resp_data` is requester i's ciphertext.
- `resp_data` output 128: registered ciphertext.
- `core_in` output 128: plaintext to the core, driven from the staging register.
- `core_key` output 128: key to the core, driven from the staging register.
- `core_ready` input 1: the core samples `core_in`/`core_key` at this posedge.
- `core_valid` input 1: `core_out` is the result of the previously sampled input.
- `core_out` input 128: ciphertext from the core.
- `stat_blocks` output 16: only present with `AES_ARB_STATS_EN` (see Configuration).

## Operation
- **State:**
  - staging: `stg_full`, `stg_data`, `stg_key`, `stg_tag`.
  - in-flight: `fl_busy`, `fl_tag`.
  - `rr_ptr[TAG_W-1:0]`.
- **Grant:** only while `stg_full == 0`.
  - Search from `rr_ptr` upward, wrapping modulo `N_REQ`; the first i with `req_valid[i]` gets `req_ready[i] = 1`.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and `stg_full`.
- **Transfer:** `req_valid[i] && req_ready[i]` at the posedge.
  - `stg_*` <= requester i's data/key/index, and `stg_full` <= 1.
  - `rr_ptr` <= (i+1) mod `N_REQ`.
- **Issue:** `core_ready && stg_full` at the posedge.
  - `fl_busy` <= 1 and `fl_tag` <= `stg_tag`.
  - `stg_full` <= 0. `stg_data`/`stg_key` hold their values.
- **Idle core:** `core_ready` with `stg_full == 0` leaves `fl_busy` unchanged. The core runs free and encrypts stale staging content, which is ignored.
- **Complete:** `core_valid && fl_busy` at the posedge.
  - `resp_valid` <= one-hot(`fl_tag`) and `resp_data` <= `core_out`.
  - `fl_busy` <= 0, unless an issue happens in the same cycle.
- **Discard:** `core_valid && !fl_busy` produces no response.
- **Simultaneous complete and issue:** the response uses the old `fl_tag`. Then `fl_busy` <= 1 and `fl_tag` <= `stg_tag`.
- **No same-cycle accept:** a staging slot freed by an issue cannot accept in the same cycle, because `req_ready` sees `stg_full == 1`. Accept resumes the next cycle.
- **Default outputs:** `resp_valid` is all-zero in every cycle without a completion. `resp_data` holds its last value.
- **`N_REQ` not a power of two:** `rr_ptr` wraps from `N_REQ-1` to 0. The search never selects an index ≥ `N_REQ`.

## Timing
- **Reset values:**
  - `req_ready` = 0 during `rst`.
  - `resp_valid` = 0 and `resp_data` = 0.
  - `core_in` = 0 and `core_key` = 0.
  - `stg_full` = 0, `fl_busy` = 0, `rr_ptr` = 0, `stat_blocks` = 0.
- **Reset mid-operation:** staged and in-flight blocks are dropped with no response. A later `core_valid` for a dropped block is discarded.
- **Latency:**
  - Accept edge to earliest issue: the next `core_ready`, at least 1 cycle later.
  - `core_valid` edge to `resp_valid`: 1 cycle (registered).
- **Core model used by the bench:**
  - `ready` period 29 cycles.
  - `valid` 28 cycles after `ready`, i.e. 1 cycle before the next `ready`.
  - The arbiter must not depend on these numbers; only the ordering "issue precedes its completion" is required.
- **Handshake rule:** `req_data`/`req_key` of requester i are sampled only on its transfer edge. A requester may drop `req_valid` at any time before it is granted.

## Configuration
- **`AES_ARB_STATS_EN` defined:**
  - Adds output `stat_blocks[15:0]`, which counts completions (`resp_valid != 0`).
  - The counter saturates at 16'hFFFF and is cleared by `rst`.
- **Not defined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Single block:** requester 0, key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - `resp_valid[0]` pulses once.
  - `resp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, 1 cycle after `core_valid`.
- **Round-robin:** all 4 requesters hold `req_valid` from reset.
  - Grants in order 0,1,2,3,0.
  - Responses return in the same order, each tagged correctly, one per 29-cycle core period.
- **Skip idle requesters:** `rr_ptr` = 2 and only requesters 0 and 3 valid.
  - Grant 3 first, then 0; `rr_ptr` ends at 1.
- **Discard path:** no request for 100 cycles.
  - Every `core_valid` yields `resp_valid` = 0; `stat_blocks` stays 0 (with `AES_ARB_STATS_EN`).
- **Reset mid-flight:** assert `rst` for 1 cycle 10 cycles after an issue.
  - No response appears for that block.
  - The next request completes normally with the correct tag.
- **Simultaneous complete and issue:** force `core_valid` and `core_ready` in the same cycle with staging full.
  - The old tag's response is emitted.
  - The new tag is in flight, and its response arrives on the following `core_valid`.
